scurve_sweep_ctrl: RTL and testbench

SCURVE_SWEEP_CTRL -- requirements
Module: scurve_sweep_ctrl

---
 rtl/scurve_sweep_ctrl.sv | 174 +++++++++++++++++
 tb/tb_scurve_sweep_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scurve_sweep_ctrl.sv
// scurve_sweep_ctrl
//   Steps a threshold DAC from Start_Dac to End_Dac. Each point is handled
//   the same way: the DAC is loaded and allowed to settle, then the S-curve
//   counter block is cleared and run. The count it returns is offered on a
//   valid/ready port, and the controller then moves on to the next code.
//   End_Dac is always the last point measured, and the code never wraps.
//
// Ports
//   Clk, reset                      clock; synchronous active-high reset
//   Sweep_Start, Sweep_Stop         start / abort pulses
//   Start_Dac, End_Dac, Dac_Step,
//   Settle_Time                     sweep setup, sampled at Sweep_Start
//   Dac_Code, Dac_Load,
//   Dac_Load_Done                   DAC code, load request, load complete
//   Scurve_Reset_n, Test_Start      clear and enable to the counter block
//   CPT_DONE, CPT_PULSE,
//   CPT_TRIGGER                     counter block completion and counts
//   Result_Data, Result_Valid,
//   Result_Ready                    per-point result:
//                                   {zero pad to 32b, code, pulse, trigger}
//   Sweep_Busy, Sweep_Done          activity level and completion pulse
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for Sweep_Start
// LOAD     | Dac_Load pulse for the current code
// WAIT_DAC | waiting for Dac_Load_Done
// SETTLE   | analog settle time (down-counter)
// CLR      | counter block held in reset for CLR_CYCLES (down-counter)
// RUN      | Test_Start high until CPT_DONE
// OUTPUT   | Result_Valid high until Result_Ready
// NEXT     | finish the sweep or step to the next code

module scurve_sweep_ctrl #(
   parameter int DAC_W      = 10,
   parameter int CLR_CYCLES = 4
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              Sweep_Start,
   input  logic              Sweep_Stop,
   input  logic [DAC_W-1:0]  Start_Dac,
   input  logic [DAC_W-1:0]  End_Dac,
   input  logic [DAC_W-1:0]  Dac_Step,
   input  logic [15:0]       Settle_Time,
   output logic [DAC_W-1:0]  Dac_Code,
   output logic              Dac_Load,
   input  logic              Dac_Load_Done,
   output logic              Scurve_Reset_n,
   output logic              Test_Start,
   input  logic              CPT_DONE,
   input  logic [15:0]       CPT_PULSE,
   input  logic [15:0]       CPT_TRIGGER,
   output logic [63:0]       Result_Data,
   output logic              Result_Valid,
   input  logic              Result_Ready,
   output logic              Sweep_Busy,
   output logic              Sweep_Done
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_WAIT_DAC = 3'd2,
      S_SETTLE   = 3'd3,
      S_CLR      = 3'd4,
      S_RUN      = 3'd5,
      S_OUTPUT   = 3'd6,
      S_NEXT     = 3'd7
   } state_t;

   state_t           state, state_nxt;
   logic [15:0]      cnt;
   logic [15:0]      settle_q;
   logic [DAC_W-1:0] end_q, step_q;
   logic             up_q;
   logic [15:0]      pulse_q, trig_q;
   logic             hold_q;        // forces Scurve_Reset_n low after reset/abort
   logic             abort;
   logic             at_end;
   logic [DAC_W:0]   sum_up, diff_dn;
   logic [DAC_W-1:0] code_step;

   assign abort  = Sweep_Stop && (state != S_IDLE);
   assign at_end = (Dac_Code == end_q);

   // The step is computed one bit wider so that a carry or borrow shows up
   // as an overshoot. Any overshoot is clamped to End_Dac.
   always_comb begin
      sum_up    = {1'b0, Dac_Code} + {1'b0, step_q};
      diff_dn   = {1'b0, Dac_Code} - {1'b0, step_q};
      code_step = end_q;
      if (up_q) begin
         if (sum_up <= {1'b0, end_q})
            code_step = sum_up[DAC_W-1:0];
      end else begin
         if (!diff_dn[DAC_W] && (diff_dn[DAC_W-1:0] >= end_q))
            code_step = diff_dn[DAC_W-1:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (Sweep_Start && !Sweep_Stop) state_nxt = S_LOAD;
         S_LOAD:     state_nxt = S_WAIT_DAC;
         S_WAIT_DAC: if (Dac_Load_Done) state_nxt = S_SETTLE;
         S_SETTLE:   if (cnt <= 16'd1) state_nxt = S_CLR;
         S_CLR:      if (cnt <= 16'd1) state_nxt = S_RUN;
         S_RUN:      if (CPT_DONE) state_nxt = S_OUTPUT;
         S_OUTPUT:   if (Result_Ready) state_nxt = S_NEXT;
         S_NEXT:     state_nxt = at_end ? S_IDLE : S_LOAD;
         default:    state_nxt = S_IDLE;
      endcase
      if (abort) state_nxt = S_IDLE;
   end

   always_comb begin
      Dac_Load       = (state == S_LOAD);
      Test_Start     = (state == S_RUN);
      Result_Valid   = (state == S_OUTPUT);
      Sweep_Busy     = (state != S_IDLE);
      Scurve_Reset_n = !((state == S_CLR) || hold_q);
      Sweep_Done     = (state == S_NEXT) && at_end && !Sweep_Stop;
      Result_Data    = {{(32-DAC_W){1'b0}}, Dac_Code, pulse_q, trig_q};
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         cnt      <= '0;
         settle_q <= '0;
         end_q    <= '0;
         step_q   <= '0;
         up_q     <= 1'b0;
         Dac_Code <= '0;
         pulse_q  <= '0;
         trig_q   <= '0;
         hold_q   <= 1'b1;
      end else begin
         hold_q <= abort;

         // A timer is loaded when its state is entered, and that state is left
         // on terminal count. A load value of 0 or 1 gives a single cycle.
         if ((state_nxt == S_SETTLE) && (state != S_SETTLE))
            cnt <= settle_q;
         else if ((state_nxt == S_CLR) && (state != S_CLR))
            cnt <= 16'(CLR_CYCLES);
         else if (cnt != 16'd0)
            cnt <= cnt - 16'd1;

         if ((state == S_IDLE) && (state_nxt == S_LOAD)) begin
            Dac_Code <= Start_Dac;
            end_q    <= End_Dac;
            step_q   <= (Dac_Step == '0) ? DAC_W'(1) : Dac_Step;
            settle_q <= Settle_Time;
            up_q     <= (Start_Dac <= End_Dac);
         end

         if ((state == S_NEXT) && (state_nxt == S_LOAD))
            Dac_Code <= code_step;

         if ((state == S_RUN) && (state_nxt == S_OUTPUT)) begin
            pulse_q <= CPT_PULSE;
            trig_q  <= CPT_TRIGGER;
         end
      end
   end

endmodule

// File: tb/tb_scurve_sweep_ctrl.sv
module tb_scurve_sweep_ctrl;
   localparam int DAC_W      = 10;
   localparam int CLR_CYCLES = 4;

   logic             Clk = 1'b0;
   logic             reset;
   logic             Sweep_Start, Sweep_Stop;
   logic [DAC_W-1:0] Start_Dac, End_Dac, Dac_Step;
   logic [15:0]      Settle_Time;
   logic [DAC_W-1:0] Dac_Code;
   logic             Dac_Load, Dac_Load_Done;
   logic             Scurve_Reset_n, Test_Start;
   logic             CPT_DONE;
   logic [15:0]      CPT_PULSE, CPT_TRIGGER;
   logic [63:0]      Result_Data;
   logic             Result_Valid, Result_Ready;
   logic             Sweep_Busy, Sweep_Done;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   always #5 Clk = ~Clk;

   scurve_sweep_ctrl #(.DAC_W(DAC_W), .CLR_CYCLES(CLR_CYCLES)) dut (
      .Clk(Clk), .reset(reset),
      .Sweep_Start(Sweep_Start), .Sweep_Stop(Sweep_Stop),
      .Start_Dac(Start_Dac), .End_Dac(End_Dac), .Dac_Step(Dac_Step),
      .Settle_Time(Settle_Time),
      .Dac_Code(Dac_Code), .Dac_Load(Dac_Load), .Dac_Load_Done(Dac_Load_Done),
      .Scurve_Reset_n(Scurve_Reset_n), .Test_Start(Test_Start),
      .CPT_DONE(CPT_DONE), .CPT_PULSE(CPT_PULSE), .CPT_TRIGGER(CPT_TRIGGER),
      .Result_Data(Result_Data), .Result_Valid(Result_Valid),
      .Result_Ready(Result_Ready),
      .Sweep_Busy(Sweep_Busy), .Sweep_Done(Sweep_Done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference list of measured codes: walk from start toward end by step,
   // landing exactly on end when the remaining distance is within one step.
   task automatic model_codes(input int s, input int e, input int st);
      int c;
      int stp;
      stp = (st == 0) ? 1 : st;
      exp_q.delete();
      c = s;
      forever begin
         exp_q.push_back(c);
         if (c == e) break;
         if (e > c) c = (e - c <= stp) ? e : c + stp;
         else       c = (c - e <= stp) ? e : c - stp;
      end
   endtask

   task automatic run_sweep(input int s, input int e, input int st, input int se,
                            input bit hold_long);
      bit          finished = 0;
      bit          prev_ts = 0, cpt_sent = 0, transferred = 0;
      int          idx = 0, done_cnt = 0;
      int          done_delay = -1, done_cyc = -100;
      int          clr_run = 0, clr_first = 0;
      int          run_wait = -1, rdy_wait = -1;
      logic [15:0] p, t;
      logic [63:0] exp_data = '0;
      logic [DAC_W-1:0] code_v;

      model_codes(s, e, st);
      @(negedge Clk);
      Start_Dac = DAC_W'(s); End_Dac = DAC_W'(e); Dac_Step = DAC_W'(st);
      Settle_Time = 16'(se); Sweep_Start = 1'b1;
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
         @(negedge Clk);
         Sweep_Start = 1'b0; Dac_Load_Done = 1'b0; CPT_DONE = 1'b0; Result_Ready = 1'b0;
         if (cyc == 0) chk("busy_on_start", Sweep_Busy, 1);
         if (transferred) begin chk("valid_drop", Result_Valid, 0); transferred = 0; end
         if (cpt_sent)    begin chk("test_start_drop", Test_Start, 0); cpt_sent = 0; end
         if (!Scurve_Reset_n) begin
            if (clr_run == 0) clr_first = cyc;
            clr_run++;
         end
         if (Test_Start && !prev_ts) begin
            chk("clr_len", clr_run, CLR_CYCLES);
            chk("settle_gap", clr_first - done_cyc, ((se == 0) ? 1 : se) + 1);
            clr_run  = 0;
            run_wait = $urandom_range(0, 3);
            // start request and new setup while running must be ignored
            Sweep_Start = 1'b1;
            Start_Dac = DAC_W'($urandom); End_Dac = DAC_W'($urandom);
            Dac_Step = DAC_W'($urandom); Settle_Time = 16'($urandom_range(0, 9));
         end
         prev_ts = Test_Start;
         if (Dac_Load) begin
            if (idx < exp_q.size()) chk("load_code", Dac_Code, exp_q[idx]);
            else                    chk("load_extra", 1, 0);
            done_delay = 1 + $urandom_range(0, 2);
         end else if (done_delay > 0) begin
            done_delay--;
            if (done_delay == 0) begin
               Dac_Load_Done = 1'b1; done_cyc = cyc; done_delay = -1;
            end
         end
         if (cyc == done_cyc + 1) begin
            // stray completion while settling
            CPT_DONE = 1'b1; CPT_PULSE = 16'($urandom); CPT_TRIGGER = 16'($urandom);
         end
         if (Test_Start) begin
            if (run_wait == 0) begin
               p = hold_long ? 16'h1234 : 16'($urandom);
               t = hold_long ? 16'h0ABC : 16'($urandom);
               CPT_PULSE = p; CPT_TRIGGER = t; CPT_DONE = 1'b1;
               cpt_sent = 1; run_wait = -1;
               code_v = (idx < exp_q.size()) ? DAC_W'(exp_q[idx]) : '0;
               exp_data = {22'd0, code_v, p, t};
            end else if (run_wait > 0) begin
               run_wait--;
            end
         end
         if (Result_Valid) begin
            chk("result_data", Result_Data, exp_data);
            chk("ts_low_in_output", Test_Start, 0);
            if (rdy_wait < 0) rdy_wait = hold_long ? 10 : $urandom_range(0, 3);
            if (rdy_wait == 0) begin
               Result_Ready = 1'b1; transferred = 1; rdy_wait = -1; idx++;
            end else begin
               rdy_wait--;
            end
         end
         if (Sweep_Done) begin
            done_cnt++;
            chk("done_after_last", idx, exp_q.size());
            finished = 1;
         end
      end
      chk("sweep_finished", finished, 1);
      chk("points", idx, exp_q.size());
      @(negedge Clk);
      Sweep_Start = 1'b0; Dac_Load_Done = 1'b0; CPT_DONE = 1'b0; Result_Ready = 1'b0;
      chk("busy_after_done", Sweep_Busy, 0);
      chk("done_single", Sweep_Done, 0);
      chk("done_count", done_cnt, 1);
   endtask

   initial begin
      reset = 1'b1; Sweep_Start = 1'b0; Sweep_Stop = 1'b0;
      Start_Dac = '0; End_Dac = '0; Dac_Step = '0; Settle_Time = '0;
      Dac_Load_Done = 1'b0; CPT_DONE = 1'b0; CPT_PULSE = '0; CPT_TRIGGER = '0;
      Result_Ready = 1'b0;

      // reset values
      @(negedge Clk);
      @(negedge Clk);
      chk("rst_busy", Sweep_Busy, 0);
      chk("rst_code", Dac_Code, 0);
      chk("rst_scurve_n", Scurve_Reset_n, 0);
      chk("rst_test_start", Test_Start, 0);
      chk("rst_data", Result_Data, 0);
      chk("rst_valid", Result_Valid, 0);
      chk("rst_load", Dac_Load, 0);
      chk("rst_done", Sweep_Done, 0);
      reset = 1'b0;
      @(negedge Clk);
      chk("rst_release_scurve_n", Scurve_Reset_n, 1);

      // stop wins over start in IDLE
      Start_Dac = 10'd77; End_Dac = 10'd80; Dac_Step = 10'd1;
      Sweep_Start = 1'b1; Sweep_Stop = 1'b1;
      @(negedge Clk);
      Sweep_Start = 1'b0; Sweep_Stop = 1'b0;
      chk("stop_start_busy", Sweep_Busy, 0);
      chk("stop_start_code", Dac_Code, 0);
      chk("stop_start_load", Dac_Load, 0);

      // directed sweeps
      run_sweep(100, 110, 5, 3, 0);
      run_sweep(20, 10, 4, 2, 1);
      run_sweep(5, 7, 0, 0, 0);
      run_sweep(1023, 1023, 1, 1, 0);
      run_sweep(1020, 1023, 7, 0, 0);
      run_sweep(3, 0, 9, 2, 0);

      // randomized sweeps
      for (int n = 0; n < 6; n++) begin
         int s, e, span;
         s    = $urandom_range(0, 1023);
         span = $urandom_range(0, 40);
         if ($urandom_range(0, 1) == 1) e = (s + span > 1023) ? 1023 : s + span;
         else                           e = (s - span < 0) ? 0 : s - span;
         run_sweep(s, e, $urandom_range(0, 12), $urandom_range(0, 5), 0);
      end

      // abort during RUN
      @(negedge Clk);
      Start_Dac = 10'd50; End_Dac = 10'd60; Dac_Step = 10'd2; Settle_Time = 16'd1;
      Sweep_Start = 1'b1; Dac_Load_Done = 1'b1;
      @(negedge Clk);
      Sweep_Start = 1'b0;
      for (int i = 0; i < 100 && !Test_Start; i++) @(negedge Clk);
      chk("abort_reach_run", Test_Start, 1);
      Sweep_Stop = 1'b1;
      @(negedge Clk);
      Sweep_Stop = 1'b0;
      chk("abort_busy", Sweep_Busy, 0);
      chk("abort_test_start", Test_Start, 0);
      chk("abort_valid", Result_Valid, 0);
      chk("abort_scurve_n", Scurve_Reset_n, 0);
      chk("abort_done", Sweep_Done, 0);
      @(negedge Clk);
      chk("abort_scurve_n_release", Scurve_Reset_n, 1);
      chk("abort_idle", Sweep_Busy, 0);
      chk("abort_no_done", Sweep_Done, 0);

      // reset during OUTPUT
      Start_Dac = 10'd300; End_Dac = 10'd200; Dac_Step = 10'd10; Settle_Time = 16'd2;
      Sweep_Start = 1'b1;
      @(negedge Clk);
      Sweep_Start = 1'b0;
      for (int i = 0; i < 100 && !Test_Start; i++) @(negedge Clk);
      chk("rstout_reach_run", Test_Start, 1);
      CPT_DONE = 1'b1; CPT_PULSE = 16'hBEEF; CPT_TRIGGER = 16'h0042;
      @(negedge Clk);
      CPT_DONE = 1'b0;
      chk("rstout_valid", Result_Valid, 1);
      chk("rstout_data", Result_Data, {22'd0, 10'd300, 16'hBEEF, 16'h0042});
      reset = 1'b1;
      @(negedge Clk);
      reset = 1'b0; Dac_Load_Done = 1'b0;
      chk("rstout_valid_low", Result_Valid, 0);
      chk("rstout_test_start", Test_Start, 0);
      chk("rstout_busy", Sweep_Busy, 0);
      chk("rstout_code", Dac_Code, 0);
      chk("rstout_data_clr", Result_Data, 0);
      chk("rstout_scurve_n", Scurve_Reset_n, 0);
      chk("rstout_done", Sweep_Done, 0);
      @(negedge Clk);
      chk("rstout_scurve_n_release", Scurve_Reset_n, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         chk("rstout_quiet_done", Sweep_Done, 0);
         chk("rstout_quiet_busy", Sweep_Busy, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
